// File: rtl/mmio_pkg.sv
// Purpose: shared register offsets, load/store size codes and FSM states for the peripheral window.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mmio_pkg;

    // Register offsets within the 16-byte window
    localparam logic [3:0] OFF_LED = 4'h0;
    localparam logic [3:0] OFF_RGB = 4'h4;
    localparam logic [3:0] OFF_US  = 4'h8;
    localparam logic [3:0] OFF_MS  = 4'hC;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {IDLE, RESP} resp_state_t;

endpackage

// File: rtl/mmio_peripheral_responder_pwm_channel.sv
// Purpose: one PWM channel; duty is shadowed at counter wrap so a period is never torn.
// Latency: new duty visible from the first count after the next wrap; output is combinational off cnt.
// Backpressure: none; free-running.
module pwm_channel #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic                wrap,
    input  logic [PWM_BITS-1:0] duty_in,
    output logic                pwm_out
);

    logic [PWM_BITS-1:0] shadow_duty;

    // Latch the programmed duty only on the edge where the shared counter rolls over to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_duty <= '0;
        end else if (wrap) begin
            shadow_duty <= duty_in;
        end
    end

    // duty 0 never matches, full-scale duty misses only the last count
    assign pwm_out = (cnt < shadow_duty);

endmodule

// File: rtl/mmio_peripheral_responder.sv
// Purpose: responder for the peripheral window: PWM duty registers, micros/millis timers, LED/RGB pins.
// Latency: request accepted at edge N, one-cycle response strobe in cycle N+1.
// Backpressure: req_ready drops for the response cycle, so at most one request every two cycles.
module mmio_peripheral_responder
    import mmio_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 12_000_000,
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FFF0,
    parameter int unsigned PWM_BITS    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

    localparam int unsigned US_DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned PSC_W  = $clog2(US_DIV + 1);

    resp_state_t         state;
    logic                accept;

    logic [PWM_BITS-1:0] led_duty;
    logic [23:0]         rgb_duty;
    logic [31:0]         micros;
    logic [31:0]         millis;
    logic [PSC_W-1:0]    presc;
    logic [9:0]          ms_div;
    logic                us_tick;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_wrap;
    logic                led_pwm;
    logic                red_pwm;
    logic                green_pwm;
    logic                blue_pwm;

    logic [31:0]         off;
    logic                in_win;
    logic [3:0]          reg_off;
    logic [31:0]         cur_word;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [31:0]         load_data;
    logic [31:0]         wmask;
    logic [31:0]         wlanes;
    logic [31:0]         new_word;
    logic                req_err;
    logic                unused_bits;

    assign accept  = req_valid && req_ready;
    assign off     = req_addr - BASE_ADDR;
    assign in_win  = (off < 32'd16);
    assign reg_off = {off[3:2], 2'b00};

    // Current contents of the addressed register, unimplemented bits reading as zero
    always_comb begin
        cur_word = 32'h0;
        case (reg_off)
            OFF_LED: cur_word = 32'(led_duty);
            OFF_RGB: cur_word = {8'h00, rgb_duty};
            OFF_US:  cur_word = micros;
            OFF_MS:  cur_word = millis;
            default: cur_word = 32'h0;
        endcase
    end

    // Lane selection and sign/zero extension for loads
    always_comb begin
        byte_sel = cur_word[7:0];
        case (req_addr[1:0])
            2'd0: byte_sel = cur_word[7:0];
            2'd1: byte_sel = cur_word[15:8];
            2'd2: byte_sel = cur_word[23:16];
            2'd3: byte_sel = cur_word[31:24];
            default: byte_sel = cur_word[7:0];
        endcase
        half_sel  = req_addr[1] ? cur_word[31:16] : cur_word[15:0];
        load_data = 32'h0;
        case (req_funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            F3_W:    load_data = cur_word;
            default: load_data = 32'h0;
        endcase
    end

    // Store merge: replicate the right-aligned data to every lane, then keep only the addressed lanes
    always_comb begin
        wmask  = 32'h0;
        wlanes = req_wdata;
        case (req_funct3)
            F3_B: begin
                wlanes = {4{req_wdata[7:0]}};
                wmask  = 32'h0000_00FF << {req_addr[1:0], 3'b000};
            end
            F3_H: begin
                wlanes = {2{req_wdata[15:0]}};
                wmask  = req_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            end
            F3_W: begin
                wlanes = req_wdata;
                wmask  = 32'hFFFF_FFFF;
            end
            default: begin
                wlanes = req_wdata;
                wmask  = 32'h0;
            end
        endcase
        new_word = (cur_word & ~wmask) | (wlanes & wmask);
    end

    // Reject out-of-window, misaligned, unsupported-size and read-only-target accesses
    always_comb begin
        req_err = !in_win;
        case (req_funct3)
            F3_B:    req_err = req_err;
            F3_BU:   req_err = req_err || req_write;
            F3_H:    req_err = req_err || req_addr[0];
            F3_HU:   req_err = req_err || req_write || req_addr[0];
            F3_W:    req_err = req_err || (req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
        if (req_write && (reg_off == OFF_US || reg_off == OFF_MS)) begin
            req_err = 1'b1;
        end
    end

    // Byte lanes above the RGB fields have no storage
    assign unused_bits = ^new_word[31:24];

    // Handshake FSM: one request in, one response strobe out, registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= RESP;
                        req_ready  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= req_err;
                        resp_rdata <= (req_write || req_err) ? 32'h0 : load_data;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

    // Duty registers update on the accept edge of a good store
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_duty <= '0;
            rgb_duty <= 24'h0;
        end else if (accept && req_write && !req_err) begin
            case (reg_off)
                OFF_LED: led_duty <= new_word[PWM_BITS-1:0];
                OFF_RGB: rgb_duty <= new_word[23:0];
                default: begin
                end
            endcase
        end
    end

    assign us_tick = (presc == PSC_W'(US_DIV - 1));

    // Microsecond prescaler feeding micros and a 0..999 divider for millis
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            ms_div <= 10'd0;
            micros <= 32'h0;
            millis <= 32'h0;
        end else begin
            presc <= us_tick ? '0 : presc + 1'b1;
            if (us_tick) begin
                micros <= micros + 32'd1;
                if (ms_div == 10'd999) begin
                    ms_div <= 10'd0;
                    millis <= millis + 32'd1;
                end else begin
                    ms_div <= ms_div + 10'd1;
                end
            end
        end
    end

    assign pwm_wrap = &pwm_cnt;

    // Shared free-running PWM period counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_led (
        .clk(clk), .rst_n(rst_n), .cnt(pwm_cnt), .wrap(pwm_wrap),
        .duty_in(led_duty), .pwm_out(led_pwm)
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_red (
        .clk(clk), .rst_n(rst_n), .cnt(pwm_cnt), .wrap(pwm_wrap),
        .duty_in(PWM_BITS'(rgb_duty[7:0])), .pwm_out(red_pwm)
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_green (
        .clk(clk), .rst_n(rst_n), .cnt(pwm_cnt), .wrap(pwm_wrap),
        .duty_in(PWM_BITS'(rgb_duty[15:8])), .pwm_out(green_pwm)
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_blue (
        .clk(clk), .rst_n(rst_n), .cnt(pwm_cnt), .wrap(pwm_wrap),
        .duty_in(PWM_BITS'(rgb_duty[23:16])), .pwm_out(blue_pwm)
    );

    // Board LED is active-high, the RGB LED sinks current so its pins are active-low
    assign led   = led_pwm;
    assign red   = ~red_pwm;
    assign green = ~green_pwm;
    assign blue  = ~blue_pwm;

endmodule

// File: tb/tb_mmio_peripheral_responder.sv
module tb_mmio_peripheral_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        led;
    logic        red;
    logic        green;
    logic        blue;

    int n_checks;
    int n_fail;
    int cyc;

    logic [31:0] rd;
    logic        er;
    int          c_led, c_red, c_grn, c_blu;
    int          pulses;

    mmio_peripheral_responder #(
        .CLK_FREQ_HZ(12_000_000),
        .BASE_ADDR  (32'hFFFF_FFF0),
        .PWM_BITS   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_funct3(req_funct3),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .led       (led),
        .red       (red),
        .green     (green),
        .blue      (blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges seen since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h, required %h", tag, observed, expected);
        end
    endtask

    // One request: drive at a falling edge, accepted at the next rising edge
    task automatic access(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, output logic [31:0] rdata, output logic err);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wd;
        check("ready_before_accept", {31'b0, req_ready}, 32'd1);
        check("no_resp_before_accept", {31'b0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("resp_one_cycle_after", {31'b0, resp_valid}, 32'd1);
        rdata = resp_rdata;
        err   = resp_err;
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("resp_single_pulse", {31'b0, resp_valid}, 32'd0);
    endtask

    task automatic pwm_count(output int n_led, output int n_red, output int n_grn, output int n_blu);
        n_led = 0; n_red = 0; n_grn = 0; n_blu = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            n_led += int'(led);
            n_red += int'(red);
            n_grn += int'(green);
            n_blu += int'(blue);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: observed no finish, required finish before 1000000");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h0;
        req_funct3 = 3'b000;
        req_wdata  = 32'h0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_req_ready",  {31'b0, req_ready},  32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata,          32'h0);
        check("rst_resp_err",   {31'b0, resp_err},   32'd0);
        check("rst_led",        {31'b0, led},        32'd0);
        check("rst_rgb",        {29'b0, red, green, blue}, 32'd7);
        rst_n = 1'b1;

        // 1: LED duty 0x80 -> half duty; RGB at duty 0 stays dark
        access(1'b1, 32'hFFFF_FFF0, 3'b010, 32'h0000_0080, rd, er);
        check("sw_led_err", {31'b0, er}, 32'd0);
        check("sw_led_rdata", rd, 32'h0);
        repeat (300) @(negedge clk);
        pwm_count(c_led, c_red, c_grn, c_blu);
        check("led_half_duty", c_led, 32'd128);
        check("red_duty0_off", c_red, 32'd256);
        check("blue_duty0_off", c_blu, 32'd256);

        // 2: RGB word then byte merge into lane 1
        access(1'b1, 32'hFFFF_FFF4, 3'b010, 32'h0040_00FF, rd, er);
        check("sw_rgb_err", {31'b0, er}, 32'd0);
        access(1'b1, 32'hFFFF_FFF5, 3'b000, 32'h0000_0011, rd, er);
        check("sb_rgb_err", {31'b0, er}, 32'd0);
        access(1'b0, 32'hFFFF_FFF4, 3'b010, 32'h0, rd, er);
        check("lw_rgb_merged", rd, 32'h0040_11FF);
        check("lw_rgb_err", {31'b0, er}, 32'd0);
        repeat (300) @(negedge clk);
        pwm_count(c_led, c_red, c_grn, c_blu);
        check("red_full_duty", c_red, 32'd1);
        check("green_duty_0x11", c_grn, 32'd239);
        check("blue_duty_0x40", c_blu, 32'd192);
        check("led_still_half", c_led, 32'd128);

        // 3: sized loads
        access(1'b0, 32'hFFFF_FFF4, 3'b000, 32'h0, rd, er);
        check("lb_sign", rd, 32'hFFFF_FFFF);
        access(1'b0, 32'hFFFF_FFF4, 3'b100, 32'h0, rd, er);
        check("lbu_zero", rd, 32'h0000_00FF);
        access(1'b0, 32'hFFFF_FFF4, 3'b101, 32'h0, rd, er);
        check("lhu_low", rd, 32'h0000_11FF);
        access(1'b0, 32'hFFFF_FFF6, 3'b001, 32'h0, rd, er);
        check("lh_high", rd, 32'h0000_0040);
        access(1'b0, 32'hFFFF_FFF5, 3'b000, 32'h0, rd, er);
        check("lb_lane1", rd, 32'h0000_0011);

        // 5: rejected accesses
        access(1'b0, 32'hFFFF_FFF1, 3'b001, 32'h0, rd, er);
        check("lh_misaligned_err", {31'b0, er}, 32'd1);
        check("lh_misaligned_rdata", rd, 32'h0);
        access(1'b1, 32'hFFFF_FFF8, 3'b010, 32'h1234_5678, rd, er);
        check("sw_micros_err", {31'b0, er}, 32'd1);
        access(1'b0, 32'h0000_0100, 3'b010, 32'h0, rd, er);
        check("lw_outside_err", {31'b0, er}, 32'd1);
        check("lw_outside_rdata", rd, 32'h0);
        access(1'b0, 32'hFFFF_FFF0, 3'b011, 32'h0, rd, er);
        check("f3_011_err", {31'b0, er}, 32'd1);
        check("f3_011_rdata", rd, 32'h0);
        access(1'b1, 32'hFFFF_FFF0, 3'b101, 32'h0000_00FF, rd, er);
        check("shu_err", {31'b0, er}, 32'd1);
        access(1'b1, 32'hFFFF_FFF2, 3'b010, 32'h0000_00FF, rd, er);
        check("sw_misaligned_err", {31'b0, er}, 32'd1);
        access(1'b0, 32'hFFFF_FFF0, 3'b010, 32'h0, rd, er);
        check("led_unchanged", rd, 32'h0000_0080);
        access(1'b0, 32'hFFFF_FFF4, 3'b010, 32'h0, rd, er);
        check("rgb_unchanged", rd, 32'h0040_11FF);

        // Unimplemented bits: LED upper bits dropped, RGB top byte dropped
        access(1'b1, 32'hFFFF_FFF0, 3'b010, 32'hABCD_EF80, rd, er);
        access(1'b0, 32'hFFFF_FFF0, 3'b010, 32'h0, rd, er);
        check("led_upper_ignored", rd, 32'h0000_0080);
        access(1'b1, 32'hFFFF_FFF6, 3'b001, 32'h0000_BEEF, rd, er);
        check("sh_rgb_err", {31'b0, er}, 32'd0);
        access(1'b0, 32'hFFFF_FFF4, 3'b010, 32'h0, rd, er);
        check("sh_rgb_top_dropped", rd, 32'h00EF_11FF);

        // 4: timers ~12000 clocks after release (accept edge 12008 returns value after 12007 edges)
        while (cyc < 12006) @(negedge clk);
        access(1'b0, 32'hFFFF_FFF8, 3'b010, 32'h0, rd, er);
        check("micros_1000", rd, 32'd1000);
        check("micros_err", {31'b0, er}, 32'd0);
        access(1'b0, 32'hFFFF_FFFC, 3'b010, 32'h0, rd, er);
        check("millis_1", rd, 32'd1);

        // 6: back-to-back requests with req_valid held
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'hFFFF_FFF0;
        req_funct3 = 3'b010;
        pulses     = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            check("b2b_ready_alternates", {31'b0, req_ready}, {31'b0, (i % 2 == 0)});
            if (resp_valid) pulses++;
        end
        check("b2b_three_pulses", pulses, 32'd3);
        check("b2b_rdata", resp_rdata, 32'h0000_0080);

        // Reset during the response cycle
        rst_n = 1'b0;
        #1;
        check("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("midrst_req_ready",  {31'b0, req_ready},  32'd1);
        check("midrst_rdata",      resp_rdata,          32'h0);
        check("midrst_led",        {31'b0, led},        32'd0);
        check("midrst_rgb",        {29'b0, red, green, blue}, 32'd7);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 32'hFFFF_FFF0, 3'b010, 32'h0, rd, er);
        check("midrst_led_reg", rd, 32'h0);
        access(1'b0, 32'hFFFF_FFF4, 3'b010, 32'h0, rd, er);
        check("midrst_rgb_reg", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
